// File: rtl/regfile_pkg.sv
// Shared types and the read-bypass source selector for the multi-port register file.
// Read lanes call rf_bypass_sel to decide where each lane's data comes from.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  typedef enum logic [1:0] {
    SEL_MEM  = 2'd0,
    SEL_WA   = 2'd1,
    SEL_WB   = 2'd2,
    SEL_ZERO = 2'd3
  } rf_sel_e;

  // Lane B is the younger retire lane, so its in-flight write shadows lane A's.
  function automatic rf_sel_e rf_bypass_sel(input logic reset, input logic zero_hit,
                                            input logic wb_hit, input logic wa_hit);
    rf_sel_e sel;
    if (reset || zero_hit) sel = SEL_ZERO;
    else if (wb_hit)       sel = SEL_WB;
    else if (wa_hit)       sel = SEL_WA;
    else                   sel = SEL_MEM;
    return sel;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read lane: selects between stored data, same-cycle
// write-port bypass, or zero (reset / hardwired zero register).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  rf_sel_e sel;

  always_comb begin
    sel = rf_bypass_sel(reset,
                        ZERO_EN && (rd_addr == '0),
                        wb_en && (wb_addr == rd_addr),
                        wa_en && (wa_addr == rd_addr));
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    unique case (sel)
      SEL_MEM:  rd_data = mem_data;
      SEL_WA:   rd_data = wa_data;
      SEL_WB:   rd_data = wb_data;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Dual-write, NUM_RD-read register file with same-cycle write-to-read bypass,
// optional hardwired zero register and synchronous clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wa_keep;
  logic              wb_keep;

  assign wa_keep = wa_en && !(ZERO_EN && (wa_addr == '0));
  assign wb_keep = wb_en && !(ZERO_EN && (wb_addr == '0));

  // NOTE: the array is flop-based and must be cleared by reset, so it cannot map
  // to a RAM macro; that is the price of a single-cycle architectural clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking writes; on an address collision the later statement
      // (lane B) is the one that lands, giving the younger lane priority.
      if (wa_keep) mem[wa_addr] <= wa_data;
      if (wb_keep) mem[wb_addr] <= wb_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] lane_addr;
    assign lane_addr = rd_addr[g*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .reset    (reset),
      .rd_addr  (lane_addr),
      .mem_data (mem[lane_addr]),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .rd_data  (rd_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed test of regfile_mp: a 3-read ZERO_REG=1 instance and a 1-read
// ZERO_REG=0 instance sharing the same write and reset stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wa_en, wb_en;
  logic [4:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [4:0]  rd_addr_nz;
  logic [31:0] rd_data_nz;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr(rd_addr_nz), .rd_data(rd_data_nz)
  );

  task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic reg_data_t lane(input int i);
    return rd_data[i*32 +: 32];
  endfunction

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic idle_writes();
    wa_en = 1'b0; wb_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_writes();
    wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    set_rd(5'd1, 5'd2, 5'd3);
    rd_addr_nz = 5'd0;

    // Two reset cycles; lanes forced to zero throughout.
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_l0", lane(0), 32'h0);
    check("reset_l1", lane(1), 32'h0);
    check("reset_l2", lane(2), 32'h0);

    // Write to the zero register is dropped and never bypassed.
    next_cycle();
    reset = 1'b0;
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h0000_FFFF;
    set_rd(5'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("zero_same_l0", lane(0), 32'h0);
    check("zero_same_l1", lane(1), 32'h0);
    next_cycle();
    idle_writes();
    @(negedge clk);
    check("zero_next_l0", lane(0), 32'h0);
    check("zero_next_l1", lane(1), 32'h0);

    // Bypass then storage.
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd2; wa_data = 32'h0000_FFF0;
    set_rd(5'd0, 5'd2, 5'd0);
    @(negedge clk);
    check("byp_same_l0", lane(0), 32'h0);
    check("byp_same_l1", lane(1), 32'h0000_FFF0);
    next_cycle();
    idle_writes();
    @(negedge clk);
    check("byp_next_l1", lane(1), 32'h0000_FFF0);

    // Collision: lane B wins for both bypass and storage.
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h0000_1111;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_2222;
    set_rd(5'd5, 5'd2, 5'd0);
    @(negedge clk);
    check("coll_same", lane(0), 32'h0000_2222);
    next_cycle();
    idle_writes();
    @(negedge clk);
    check("coll_mem", lane(0), 32'h0000_2222);

    // Split writes with two lanes reading the same register.
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'h0000_1000;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_ABCD;
    set_rd(5'd1, 5'd3, 5'd1);
    @(negedge clk);
    check("split_same_l0", lane(0), 32'h0000_1000);
    check("split_same_l1", lane(1), 32'h0000_ABCD);
    check("split_same_l2", lane(2), 32'h0000_1000);
    next_cycle();
    idle_writes();
    @(negedge clk);
    check("split_next_l0", lane(0), 32'h0000_1000);
    check("split_next_l1", lane(1), 32'h0000_ABCD);
    check("split_next_l2", lane(2), 32'h0000_1000);

    // Fill r1..r4, then reset mid-stream with a write pending.
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'hA5A5_0001;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hA5A5_0002;
    next_cycle();
    wa_addr = 5'd3; wa_data = 32'hA5A5_0003;
    wb_addr = 5'd4; wb_data = 32'hA5A5_0004;
    next_cycle();
    idle_writes();
    set_rd(5'd1, 5'd3, 5'd4);
    @(negedge clk);
    check("fill_r1", lane(0), 32'hA5A5_0001);
    check("fill_r3", lane(1), 32'hA5A5_0003);
    check("fill_r4", lane(2), 32'hA5A5_0004);

    next_cycle();
    reset = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h0000_DEAD;
    set_rd(5'd4, 5'd1, 5'd2);
    @(negedge clk);
    check("rst_mid_l0", lane(0), 32'h0);
    check("rst_mid_l1", lane(1), 32'h0);
    check("rst_mid_l2", lane(2), 32'h0);
    next_cycle();
    reset = 1'b0;
    idle_writes();
    set_rd(5'd1, 5'd2, 5'd3);
    @(negedge clk);
    check("post_rst_r1", lane(0), 32'h0);
    check("post_rst_r2", lane(1), 32'h0);
    check("post_rst_r3", lane(2), 32'h0);
    next_cycle();
    set_rd(5'd4, 5'd4, 5'd4);
    @(negedge clk);
    check("post_rst_r4", lane(0), 32'h0);

    // Register 0 is ordinary in the ZERO_REG=0 instance.
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h0000_1234;
    set_rd(5'd0, 5'd0, 5'd0);
    rd_addr_nz = 5'd0;
    @(negedge clk);
    check("nz_byp", rd_data_nz, 32'h0000_1234);
    check("z_byp_r0", lane(0), 32'h0);
    next_cycle();
    idle_writes();
    @(negedge clk);
    check("nz_mem", rd_data_nz, 32'h0000_1234);
    check("z_mem_r0", lane(0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
